// File: rtl/hybrid_row_alloc.sv
// hybrid_row_alloc
//   Allocates cells for three requesters into a column of hybrid rows.
//   Even rows are A-site rows and odd rows are G-site rows. A request is one
//   of A, G, AG (an even row plus the odd row above it) or GA (an odd row plus
//   the even row above it). A round-robin arbiter captures one requester.
//   The search then checks one row per cycle, lowest row first, and ends with
//   a single-cycle grant or reject pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req[2:0]   per-requester request; held high until its gnt/nack pulse
//   req_type   2 bits per requester: 0=A 1=G 2=AG 3=GA
//   clear      synchronous clear of all row occupancy; aborts a search
//   gnt, nack  one-hot grant / reject pulse, one cycle long
//   gnt_row    base row of the grant, valid with gnt, otherwise 0
//   busy       high while a request is being searched or answered
//
// Optional build (define HYBRID_ROW_STATS_EN)
//   grant_cnt, nack_cnt  saturating 16-bit pulse counters; rst clears them,
//                        clear does not.
module hybrid_row_alloc #(
    parameter int NUM_ROWS = 8,
    parameter int ROW_CAP  = 4,
    parameter int ROW_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [5:0]       req_type,
    input  logic             clear,
    output logic [2:0]       gnt,
    output logic [2:0]       nack,
    output logic [ROW_W-1:0] gnt_row,
    output logic             busy
`ifdef HYBRID_ROW_STATS_EN
    ,
    output logic [15:0]      grant_cnt,
    output logic [15:0]      nack_cnt
`endif
);

    localparam int CW = $clog2(ROW_CAP + 1);
    localparam logic [CW-1:0] CAP = CW'(ROW_CAP);

    typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

    state_t                     state, state_nx;
    logic [1:0]                 ptr;       // first requester to consider next
    logic [1:0]                 cur;       // captured requester
    logic [1:0]                 cur_type;
    logic [ROW_W-1:0]           row;       // row being evaluated
    logic [NUM_ROWS-1:0][CW-1:0] occ;

    logic                       pick_vld;
    logic [1:0]                 pick;
    logic                       fit, last, pair, ok_r, ok_n;
    logic [ROW_W-1:0]           row_nx;
    logic                       gnt_fire, nack_fire;
    logic [NUM_ROWS-1:0]        inc;

    assign busy = (state != IDLE);

    // Round-robin pick: scan from ptr upward, wrapping at 3.
    always_comb begin
        int j;
        pick_vld = 1'b0;
        pick     = 2'd0;
        j        = 0;
        for (int k = 0; k < 3; k++) begin
            j = (int'(ptr) + k) % 3;
            if (!pick_vld && req[j[1:0]]) begin
                pick_vld = 1'b1;
                pick     = j[1:0];
            end
        end
    end

    // Fit test for the current row. row_nx is clamped on the top row so the
    // partner lookup never leaves the array; ok_n masks it out there anyway.
    always_comb begin
        last   = (int'(row) == NUM_ROWS - 1);
        pair   = cur_type[1];
        row_nx = last ? row : row + 1'b1;
        ok_r   = (occ[row] < CAP);
        ok_n   = !last && (occ[row_nx] < CAP);
        case (cur_type)
            2'd0:    fit = !row[0] && ok_r;
            2'd1:    fit =  row[0] && ok_r;
            2'd2:    fit = !row[0] && ok_r && ok_n;
            default: fit =  row[0] && ok_r && ok_n;
        endcase
    end

    assign gnt_fire  = (state == SEARCH) && !clear && fit;
    assign nack_fire = (state == SEARCH) && !clear && !fit && last;

    always_comb begin
        inc = '0;
        for (int g = 0; g < NUM_ROWS; g++)
            inc[g] = gnt_fire && ((int'(row) == g) || (pair && int'(row) + 1 == g));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_vld) state_nx = SEARCH;
            SEARCH:  if (clear) state_nx = IDLE;
                     else if (fit || last) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            cur      <= 2'd0;
            cur_type <= 2'd0;
            row      <= '0;
            gnt      <= 3'd0;
            nack     <= 3'd0;
            gnt_row  <= '0;
        end else begin
            state   <= state_nx;
            gnt     <= 3'd0;
            nack    <= 3'd0;
            gnt_row <= '0;
            if (state == IDLE && pick_vld) begin
                cur      <= pick;
                cur_type <= req_type[{pick, 1'b0} +: 2];
                row      <= '0;
                ptr      <= (pick == 2'd2) ? 2'd0 : pick + 2'd1;
            end
            if (gnt_fire) begin
                gnt     <= 3'd1 << cur;
                gnt_row <= row;
            end
            if (nack_fire)
                nack <= 3'd1 << cur;
            if (state == SEARCH && !clear && !fit && !last)
                row <= row + 1'b1;
        end
    end

    // Occupancy: clear wins; the fit test already guarantees room, the cap
    // guard just keeps a counter from ever wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            for (int g = 0; g < NUM_ROWS; g++) begin
                if (clear)
                    occ[g] <= '0;
                else if (inc[g] && occ[g] != CAP)
                    occ[g] <= occ[g] + 1'b1;
            end
        end
    end

`ifdef HYBRID_ROW_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= 16'd0;
            nack_cnt  <= 16'd0;
        end else begin
            if (gnt_fire && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
            if (nack_fire && nack_cnt != 16'hFFFF) nack_cnt <= nack_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/hybrid_row_alloc.md
HYBRID_ROW_ALLOC -- requirements
Module: hybrid_row_alloc

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 8, number of hybrid rows; even index = A-site row, odd index = G-site row.
REQ-002 SHALL have parameter ROW_CAP, default 4, max cells per row.
REQ-003 SHALL have parameter ROW_W, default 3, width of row index; ROW_W SHALL satisfy 2^ROW_W >= NUM_ROWS.
REQ-004 SHALL have ports, in order: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  in  3  per-requester request, held until gnt/nack.
REQ-007 SHALL have port req_type  in  6  2 bits per requester ([2i+1:2i]); 0=A, 1=G, 2=AG, 3=GA.
REQ-008 SHALL have port clear  in  1  synchronous occupancy clear.
REQ-009 SHALL have port gnt  out  3  one-hot grant pulse.
REQ-010 SHALL have port nack  out  3  one-hot reject pulse.
REQ-011 SHALL have port gnt_row  out  ROW_W  base row of grant, valid with gnt.
REQ-012 SHALL have port busy  out  1  high in SEARCH or RESP.

Function
REQ-013 SHALL implement FSM IDLE, SEARCH, RESP, plus one occupancy counter per row, 0..ROW_CAP.
REQ-014 In IDLE with any req high, SHALL capture one requester round-robin: start after last captured; the pointer starts at requester 0 after reset.
REQ-015 At the capture edge, SHALL latch its type, set scan row r=0, and enter SEARCH.
REQ-016 SHALL evaluate one row per SEARCH cycle; fit rules:
- A: r even, occ[r]<ROW_CAP.
- G: r odd, occ[r]<ROW_CAP.
- AG: r even, r+1<NUM_ROWS, occ[r] and occ[r+1] both <ROW_CAP.
- GA: r odd, with the same conditions as AG.
REQ-017 On fit, the next edge SHALL enter RESP, increment occ[r] (and occ[r+1] for AG/GA), and register gnt one-hot plus gnt_row=r.
REQ-018 On no fit at r=NUM_ROWS-1, the next edge SHALL enter RESP with nack one-hot, gnt_row=0, and occupancy unchanged.
REQ-019 Latency SHALL be r+2 cycles from the capture edge to the end of the gnt/nack pulse; gnt/nack SHALL be high exactly one cycle (RESP).
REQ-020 RESP SHALL always go to IDLE; the requester SHALL drop req at the edge ending RESP, and a req still high in IDLE SHALL be re-arbitrated.
REQ-021 gnt and nack SHALL never be high together; at most one bit SHALL be set in each.
REQ-022 clear SHALL zero all occupancy counters at the next edge and abort any SEARCH to IDLE, with no gnt/nack for the aborted requester.
REQ-023 clear in RESP SHALL still let the pulse complete, then zero occupancy.
REQ-024 Counters SHALL saturate at ROW_CAP and SHALL never wrap.

Reset
REQ-025 rst high SHALL asynchronously force IDLE, all occupancy 0, the round-robin pointer to 0, and gnt, nack, gnt_row and busy to 0.
REQ-026 rst during SEARCH or RESP SHALL discard the in-flight request with no pulse after release.

Configuration
REQ-027 Macro HYBRID_ROW_STATS_EN, when defined, SHALL add outputs grant_cnt[15:0] and nack_cnt[15:0]:
- Each SHALL increment on every gnt/nack pulse and saturate at 16'hFFFF.
- Each SHALL be reset to 0 by rst; clear SHALL NOT reset them.
REQ-028 When HYBRID_ROW_STATS_EN is undefined, these ports and counters SHALL be absent; the remaining behaviour SHALL be identical.

Verification (NUM_ROWS=8, ROW_CAP=2)
REQ-029 Reset: assert rst mid-SEARCH -> gnt=0, nack=0, busy=0 immediately; no pulse after release.
REQ-030 req=001, type A -> gnt=001, gnt_row=0, 2 cycles after capture; then type G -> gnt_row=1, 3 cycles after capture.
REQ-031 req=111, all type A, held -> grants in order 001, 010, 100 with gnt_row 0, 0, 2.
REQ-032 Four AG from requester 0 -> rows 0, 0, 2, 2; occ[1]=occ[3]=2; then a type G request -> gnt_row=5.
REQ-033 Sequence:
- Fill all rows, then GA -> nack=001 after 9 cycles.
- Pulse clear, then GA -> gnt_row=1.
- With HYBRID_ROW_STATS_EN, nack_cnt=1.
REQ-034 clear asserted in the 2nd SEARCH cycle -> FSM IDLE next edge, no pulse; held req is re-captured and granted row 0.
